label_mmu: RTL and testbench
============================

Name: label_mmu

Overview:
- Responder side of the datapath's MMU request interface, and owner of the label table that the datapath writes via LBSET.
- Stores per-label {type, base, count} entries and translates (reqType, lbid, ofs) requests into a physical address with bounds and type checking.
- Sits between the datapath and memory. The datapath issues requests in EXEC_1/STORE_0 and consumes mmu_addr/mmu_invalid.

Parameters:
ENTRIES, 16, number of label table slots; valid lbid range 0..ENTRIES-1
LBTYPE_UNDEFINED, 6'h00, wildcard request type that skips the type check

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
lbt_we  in  1  label table write enable
lbt_lbidw  in  12  label id to write
lbt_typw  in  6  label type
lbt_basew  in  16  label base address
lbt_countw  in  16  label length in words
req_valid  in  1  translation request present
req_ready  out  1  responder can accept a request
mmu_reqType  in  6  expected label type
mmu_lbid  in  12  label id
mmu_ofs  in  16  offset within label
rsp_valid  out  1  one-cycle pulse: result valid
mmu_addr  out  16  translated address
mmu_invalid  out  1  translation failed
mmu_fault  out  3  0 none, 1 lbid range, 2 unset, 3 type, 4 bounds

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low.
- Reset state:
  - All entry valid bits cleared; entry data don't-care.
  - FSM in IDLE, req_ready=1.
  - rsp_valid=0, mmu_addr=0, mmu_invalid=0, mmu_fault=0.
- Table write:
  - When lbt_we=1 and lbt_lbidw<ENTRIES, the entry is written and marked valid at the clock edge.
  - When lbt_lbidw>=ENTRIES, the write is silently dropped.
  - Writes are accepted in every FSM state.
- FSM states IDLE -> LOOKUP -> RESP -> IDLE:
  - IDLE: req_ready=1. On req_valid&req_ready, latch reqType/lbid/ofs and go to LOOKUP.
  - LOOKUP: req_ready=0. Read the entry for the latched lbid, evaluate checks, register the result, go to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Latency: request accepted at edge N; rsp_valid is high in the cycle after edge N+2.
  - Throughput: one request per 3 cycles.
- Output hold: mmu_addr, mmu_invalid and mmu_fault hold their last response value until the next RESP. They do not return to 0.
- Check priority (first failing check wins):
  1. lbid>=ENTRIES -> fault 1
  2. entry not valid -> fault 2
  3. reqType!=LBTYPE_UNDEFINED and reqType!=entry type -> fault 3
  4. ofs>=count (unsigned) -> fault 4
- Result on fault: mmu_invalid=1, mmu_addr=0.
- Result on success: mmu_invalid=0, mmu_fault=0, mmu_addr=(base+ofs) mod 2^16 (16-bit wrap, carry discarded).
- Boundaries:
  - count=0: every offset faults with code 4.
  - ofs=count-1 is valid.
- Write/read hazard:
  - A write committed at or before the accept edge is visible to the lookup.
  - A write in the LOOKUP cycle commits at the same edge as the read and is NOT visible; the old entry is used.
- req_valid outside IDLE is ignored and not queued.
- Reset mid-operation: abort immediately to IDLE, rsp_valid=0, table invalidated, in-flight request discarded.

Test Plan:
- LBSET write (lbid=3, typ=6'h02, base=16'h0100, count=16'h0010); request (typ 02, lbid 3, ofs 5) -> rsp_valid 2 cycles after accept, mmu_addr=16'h0105, mmu_invalid=0, fault=0.
- Same entry, ofs=16'h000F -> addr 16'h010F valid; ofs=16'h0010 -> invalid, fault=4; reqType=6'h03 -> invalid, fault=3; reqType=0 -> valid.
- After reset, request lbid 3 -> fault=2. Request lbid 16 (ENTRIES=16) -> fault=1. Write to lbid 20 then request lbid 20 -> still fault 1.
- base=16'hFFF0, count=16'h0100, ofs=16'h0020 -> addr 16'h0010, valid (wrap).
- Hazard and back-pressure:
  - Write lbid 3 with base 16'h0200 in the LOOKUP cycle -> response uses base 16'h0100.
  - Next request -> 16'h0205.
  - req_valid held high continuously -> req_ready pulses every third cycle, one response per 3 cycles.
- Assert reset_n=0 during LOOKUP -> rsp_valid never pulses, req_ready=1 after release, prior entries gone (fault 2).

Source files
------------

// File: rtl/label_mmu.sv
// Label table plus translation responder for the datapath MMU port.
// Requests walk IDLE -> LOOKUP -> RESP; table writes land in any state.
module label_mmu #(
  parameter int          ENTRIES          = 16,
  parameter logic [5:0]  LBTYPE_UNDEFINED = 6'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lbt_we,
  input  logic [11:0] lbt_lbidw,
  input  logic [5:0]  lbt_typw,
  input  logic [15:0] lbt_basew,
  input  logic [15:0] lbt_countw,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  mmu_reqType,
  input  logic [11:0] mmu_lbid,
  input  logic [15:0] mmu_ofs,
  output logic        rsp_valid,
  output logic [15:0] mmu_addr,
  output logic        mmu_invalid,
  output logic [2:0]  mmu_fault
);

  localparam int          IW  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [11:0] ENT = 12'(ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [ENTRIES-1:0] vld_q, vld_d;
  logic [5:0]  typ_q  [ENTRIES];
  logic [5:0]  typ_d  [ENTRIES];
  logic [15:0] base_q [ENTRIES];
  logic [15:0] base_d [ENTRIES];
  logic [15:0] cnt_q  [ENTRIES];
  logic [15:0] cnt_d  [ENTRIES];

  logic [5:0]  rtyp_q, rtyp_d;
  logic [11:0] lbid_q, lbid_d;
  logic [15:0] ofs_q, ofs_d;

  logic [15:0] res_addr_q, res_addr_d;
  logic        res_inv_q, res_inv_d;
  logic [2:0]  res_flt_q, res_flt_d;

  logic [15:0] addr_q, addr_d;
  logic        inv_q, inv_d;
  logic [2:0]  flt_q, flt_d;
  logic        rsp_q, rsp_d;

  logic          wr_ok;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] lk_idx;
  logic [5:0]    ent_typ;
  logic [15:0]   ent_base;
  logic [15:0]   ent_cnt;
  logic [2:0]    chk_flt;

  assign wr_ok  = lbt_we && (lbt_lbidw < ENT);
  assign wr_idx = lbt_lbidw[IW-1:0];

  always_comb begin
    vld_d  = vld_q;
    typ_d  = typ_q;
    base_d = base_q;
    cnt_d  = cnt_q;
    if (wr_ok) begin
      vld_d[wr_idx]  = 1'b1;
      typ_d[wr_idx]  = lbt_typw;
      base_d[wr_idx] = lbt_basew;
      cnt_d[wr_idx]  = lbt_countw;
    end
  end

  // Lookup reads the pre-edge table, so a same-cycle write is not seen.
  assign lk_idx   = lbid_q[IW-1:0];
  assign ent_typ  = typ_q[lk_idx];
  assign ent_base = base_q[lk_idx];
  assign ent_cnt  = cnt_q[lk_idx];

  always_comb begin
    chk_flt = 3'd0;
    if (lbid_q >= ENT)
      chk_flt = 3'd1;
    else if (!vld_q[lk_idx])
      chk_flt = 3'd2;
    else if (rtyp_q != LBTYPE_UNDEFINED && rtyp_q != ent_typ)
      chk_flt = 3'd3;
    else if (ofs_q >= ent_cnt)
      chk_flt = 3'd4;
  end

  always_comb begin
    state_d    = state_q;
    rtyp_d     = rtyp_q;
    lbid_d     = lbid_q;
    ofs_d      = ofs_q;
    res_addr_d = res_addr_q;
    res_inv_d  = res_inv_q;
    res_flt_d  = res_flt_q;
    addr_d     = addr_q;
    inv_d      = inv_q;
    flt_d      = flt_q;
    rsp_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rtyp_d  = mmu_reqType;
          lbid_d  = mmu_lbid;
          ofs_d   = mmu_ofs;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        res_flt_d  = chk_flt;
        res_inv_d  = (chk_flt != 3'd0);
        res_addr_d = (chk_flt != 3'd0) ? 16'h0000 : ent_base + ofs_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        addr_d  = res_addr_q;
        inv_d   = res_inv_q;
        flt_d   = res_flt_q;
        rsp_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      vld_q      <= '0;
      rtyp_q     <= '0;
      lbid_q     <= '0;
      ofs_q      <= '0;
      res_addr_q <= '0;
      res_inv_q  <= 1'b0;
      res_flt_q  <= '0;
      addr_q     <= '0;
      inv_q      <= 1'b0;
      flt_q      <= '0;
      rsp_q      <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        typ_q[i]  <= '0;
        base_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      typ_q      <= typ_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      rtyp_q     <= rtyp_d;
      lbid_q     <= lbid_d;
      ofs_q      <= ofs_d;
      res_addr_q <= res_addr_d;
      res_inv_q  <= res_inv_d;
      res_flt_q  <= res_flt_d;
      addr_q     <= addr_d;
      inv_q      <= inv_d;
      flt_q      <= flt_d;
      rsp_q      <= rsp_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_q;
  assign mmu_addr    = addr_q;
  assign mmu_invalid = inv_q;
  assign mmu_fault   = flt_q;

endmodule

// File: tb/tb_label_mmu.sv
// Directed bench for label_mmu: vector table of translations
// plus hazard, back-pressure and mid-flight reset sequences.
module tb_label_mmu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lbt_we;
  logic [11:0] lbt_lbidw;
  logic [5:0]  lbt_typw;
  logic [15:0] lbt_basew;
  logic [15:0] lbt_countw;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  mmu_reqType;
  logic [11:0] mmu_lbid;
  logic [15:0] mmu_ofs;
  logic        rsp_valid;
  logic [15:0] mmu_addr;
  logic        mmu_invalid;
  logic [2:0]  mmu_fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  label_mmu dut (
    .clk(clk), .reset_n(reset_n),
    .lbt_we(lbt_we), .lbt_lbidw(lbt_lbidw),
    .lbt_typw(lbt_typw), .lbt_basew(lbt_basew),
    .lbt_countw(lbt_countw),
    .req_valid(req_valid), .req_ready(req_ready),
    .mmu_reqType(mmu_reqType), .mmu_lbid(mmu_lbid),
    .mmu_ofs(mmu_ofs), .rsp_valid(rsp_valid),
    .mmu_addr(mmu_addr), .mmu_invalid(mmu_invalid),
    .mmu_fault(mmu_fault)
  );

  typedef struct packed {
    logic [5:0]  typ;
    logic [11:0] lbid;
    logic [15:0] ofs;
    logic [15:0] addr;
    logic        inv;
    logic [2:0]  flt;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [11:0] id, input logic [5:0] t,
                    input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    lbt_we = 1'b1; lbt_lbidw = id; lbt_typw = t;
    lbt_basew = b; lbt_countw = c;
    @(negedge clk);
    lbt_we = 1'b0;
  endtask

  task automatic req(input string nm, input logic [5:0] t,
                     input logic [11:0] id, input logic [15:0] o,
                     input logic [15:0] ea, input logic ei,
                     input logic [2:0] ef);
    int n;
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; mmu_reqType = t; mmu_lbid = id; mmu_ofs = o;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no rsp_valid in 8 cycles", nm);
    end else begin
      chk({nm, " latency"}, 32'(n), 32'd3);
      chk({nm, " addr"}, 32'(mmu_addr), 32'(ea));
      chk({nm, " inv"}, 32'(mmu_invalid), 32'(ei));
      chk({nm, " fault"}, 32'(mmu_fault), 32'(ef));
      @(negedge clk);
      chk({nm, " pulse"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int rdy_cnt;
    int rsp_cnt;
    int bad;
    vt[0]  = '{6'h02, 12'd3,  16'h0005, 16'h0105, 1'b0, 3'd0};
    vt[1]  = '{6'h02, 12'd3,  16'h000F, 16'h010F, 1'b0, 3'd0};
    vt[2]  = '{6'h02, 12'd3,  16'h0010, 16'h0000, 1'b1, 3'd4};
    vt[3]  = '{6'h03, 12'd3,  16'h0005, 16'h0000, 1'b1, 3'd3};
    vt[4]  = '{6'h00, 12'd3,  16'h0005, 16'h0105, 1'b0, 3'd0};
    vt[5]  = '{6'h03, 12'd3,  16'h0010, 16'h0000, 1'b1, 3'd3};
    vt[6]  = '{6'h0A, 12'd5,  16'h0020, 16'h0010, 1'b0, 3'd0};
    vt[7]  = '{6'h01, 12'd7,  16'h0000, 16'h0000, 1'b1, 3'd4};
    vt[8]  = '{6'h00, 12'd4,  16'h0000, 16'h0000, 1'b1, 3'd2};
    vt[9]  = '{6'h3F, 12'd15, 16'hFFFE, 16'hFFFE, 1'b0, 3'd0};
    vt[10] = '{6'h05, 12'd4,  16'h0000, 16'h0000, 1'b1, 3'd2};
    vt[11] = '{6'h02, 12'd16, 16'h0000, 16'h0000, 1'b1, 3'd1};
    vt[12] = '{6'h00, 12'd20, 16'h0000, 16'h0000, 1'b1, 3'd1};
    vt[13] = '{6'h00, 12'd15, 16'hFFFF, 16'h0000, 1'b1, 3'd4};
    vt[14] = '{6'h02, 12'd3,  16'h0000, 16'h0100, 1'b0, 3'd0};

    reset_n = 1'b0; lbt_we = 1'b0; lbt_lbidw = '0; lbt_typw = '0;
    lbt_basew = '0; lbt_countw = '0; req_valid = 1'b0;
    mmu_reqType = '0; mmu_lbid = '0; mmu_ofs = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst rsp", 32'(rsp_valid), 32'd0);
    chk("rst addr", 32'(mmu_addr), 32'd0);
    chk("rst inv", 32'(mmu_invalid), 32'd0);
    chk("rst fault", 32'(mmu_fault), 32'd0);
    reset_n = 1'b1;

    req("unset3", 6'h02, 12'd3, 16'h0005, 16'h0000, 1'b1, 3'd2);

    wr(12'd3,  6'h02, 16'h0100, 16'h0010);
    wr(12'd5,  6'h0A, 16'hFFF0, 16'h0100);
    wr(12'd7,  6'h01, 16'h1234, 16'h0000);
    wr(12'd15, 6'h3F, 16'h0000, 16'hFFFF);
    wr(12'd20, 6'h00, 16'h0000, 16'h0100);

    for (int i = 0; i < NV; i++)
      req($sformatf("vec%0d", i), vt[i].typ, vt[i].lbid, vt[i].ofs,
          vt[i].addr, vt[i].inv, vt[i].flt);

    repeat (4) @(negedge clk);
    chk("hold addr", 32'(mmu_addr), 32'h0100);
    chk("hold rsp", 32'(rsp_valid), 32'd0);

    // Write lands in the LOOKUP cycle: old base must be used.
    @(negedge clk);
    req_valid = 1'b1; mmu_reqType = 6'h02;
    mmu_lbid = 12'd3; mmu_ofs = 16'h0005;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lbt_we = 1'b1; lbt_lbidw = 12'd3; lbt_typw = 6'h02;
    lbt_basew = 16'h0200; lbt_countw = 16'h0010;
    @(posedge clk);
    #1 lbt_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("haz rsp", 32'(rsp_valid), 32'd1);
    chk("haz addr", 32'(mmu_addr), 32'h0105);
    req("haz next", 6'h02, 12'd3, 16'h0005, 16'h0205, 1'b0, 3'd0);

    // req_valid held high: accept every third cycle.
    repeat (2) @(negedge clk);
    req_valid = 1'b1; mmu_reqType = 6'h00;
    mmu_lbid = 12'd3; mmu_ofs = 16'h0001;
    rdy_cnt = 0; rsp_cnt = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) rdy_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (req_ready !== (i % 3 == 0)) bad++;
      if (rsp_valid !== (i >= 3 && i % 3 == 0)) bad++;
    end
    req_valid = 1'b0;
    chk("bp ready cnt", 32'(rdy_cnt), 32'd4);
    chk("bp rsp cnt", 32'(rsp_cnt), 32'd3);
    chk("bp pattern", 32'(bad), 32'd0);
    @(negedge clk);
    chk("bp drain rsp", 32'(rsp_valid), 32'd1);
    chk("bp addr", 32'(mmu_addr), 32'h0201);
    @(negedge clk);
    chk("bp no extra", 32'(rsp_valid), 32'd0);

    // Reset while a lookup is in flight.
    @(negedge clk);
    req_valid = 1'b1; mmu_reqType = 6'h02;
    mmu_lbid = 12'd3; mmu_ofs = 16'h0002;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mrst ready", 32'(req_ready), 32'd1);
    chk("mrst addr", 32'(mmu_addr), 32'd0);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("mrst no rsp", 32'(bad), 32'd0);
    chk("mrst ready2", 32'(req_ready), 32'd1);
    req("mrst gone", 6'h02, 12'd3, 16'h0005, 16'h0000, 1'b1, 3'd2);
    req("mrst gone5", 6'h0A, 12'd5, 16'h0000, 16'h0000, 1'b1, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
